wb_narrow_seq: RTL and testbench
================================

WB_NARROW_SEQ -- requirements
Module: wb_narrow_seq

Interface
REQ-001 SHALL have parameter aw, default 32, giving the address width of both ports.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the slave-response watchdog limit in cycles (range 1..65535).
REQ-003 SHALL have ports: wb_clk_i in 1 clock; wb_rst_i in 1 synchronous active-low reset.
REQ-004 SHALL have master ports: wbm_adr_i in aw; wbm_dat_i in 32; wbm_sel_i in 4; wbm_we_i, wbm_cyc_i, wbm_stb_i in 1; wbm_cti_i in 3; wbm_bte_i in 2; wbm_dat_o out 32; wbm_ack_o, wbm_err_o, wbm_rty_o out 1.
REQ-005 SHALL have slave ports: wbs_adr_o out aw; wbs_dat_o out 8; wbs_we_o, wbs_cyc_o, wbs_stb_o out 1; wbs_cti_o out 3; wbs_bte_o out 2; wbs_dat_i in 8; wbs_ack_i, wbs_err_i, wbs_rty_i in 1.

Function
REQ-006 SHALL split one 32-bit classic master access into one 8-bit slave access per set bit of wbm_sel_i, in order sel[3], sel[2], sel[1], sel[0].
REQ-007 SHALL use big-endian lane mapping: sel bit k -> slave address {wbm_adr_i[aw-1:2], 2'd(3-k)}, data lane bits [8k+7:8k].
REQ-008 SHALL implement states IDLE, ACCESS, RETRY, RESP; all slave outputs and master ack/err/dat registered.
REQ-009 IDLE: on wbm_cyc_i & wbm_stb_i, SHALL latch adr, dat, sel, we and go to ACCESS, driving the first byte in the next cycle; if sel==0, SHALL go directly to RESP with no slave cycle.
REQ-010 ACCESS: SHALL hold wbs_cyc_o=wbs_stb_o=1, wbs_cti_o=3'b000, wbs_bte_o=2'b00, wbs_we_o=latched we, wbs_dat_o=latched write byte for the current lane.
REQ-011 On wbs_ack_i in ACCESS, SHALL store wbs_dat_i into the read buffer lane, clear that pending bit, and present the next lane's address/data in the following cycle with stb kept high; if no bits remain pending, SHALL drop wbs_cyc_o/wbs_stb_o and go to RESP.
REQ-012 On wbs_err_i in ACCESS, SHALL abort remaining lanes, drop wbs_cyc_o/wbs_stb_o next cycle, and go to RESP flagged error.
REQ-013 On wbs_rty_i in ACCESS, SHALL go to RETRY: wbs_stb_o=0 (cyc held) for exactly one cycle, then reissue the same lane in ACCESS.
REQ-014 Simultaneous ack/err/rty SHALL be prioritised err > ack > rty.
REQ-015 RESP: SHALL assert exactly one of wbm_ack_o or wbm_err_o for one cycle, then return to IDLE; wbm_rty_o SHALL be constantly 0.
REQ-016 wbm_dat_o SHALL equal the read buffer with unselected lanes zero during the ack cycle, and 0 at all other times.
REQ-017 Read buffer SHALL be cleared on each new accept in IDLE.
REQ-018 If wbm_cyc_i falls while in ACCESS or RETRY, SHALL drop slave cyc/stb next cycle and return to IDLE without master ack/err.
REQ-019 wbm_cti_i and wbm_bte_i SHALL be ignored; every master access is treated as classic.
REQ-020 Latency: n selected lanes with single-cycle slave ack SHALL produce wbm_ack_o n+2 cycles after accept.

Reset
REQ-021 On wb_rst_i==0 at a clock edge, SHALL enter IDLE and drive all outputs 0, clear pending bits, read buffer and watchdog counter.
REQ-022 Reset mid-transfer SHALL take effect in the next cycle with no master ack/err issued.

Configuration
REQ-023 With macro WB_NARROW_SEQ_TIMEOUT_EN defined, SHALL count cycles in ACCESS since the last lane issue and, on reaching TIMEOUT without ack/err/rty, abort as per REQ-012 (master err).
REQ-024 Without WB_NARROW_SEQ_TIMEOUT_EN, SHALL contain no watchdog counter and wait indefinitely; TIMEOUT unused.

Verification
REQ-025 Read, adr=0x100, sel=4'b1111, slave returns 0x11,0x22,0x33,0x44 -> slave adr 0x100..0x103 in order, wbm_dat_o=0x11223344, one ack.
REQ-026 Write, adr=0x204, dat=0xAABBCCDD, sel=4'b0011 -> two slave writes: adr 0x206 data 0xCC, adr 0x207 data 0xDD; then one master ack.
REQ-027 Read sel=4'b1111, slave err on second byte -> only two slave accesses, one wbm_err_o, no ack.
REQ-028 Read sel=4'b0100, slave rty once then ack 0x5A -> stb low one cycle, adr 0x..1 reissued, wbm_dat_o=0x005A0000.
REQ-029 sel=4'b0000 -> no slave cyc, wbm_ack_o two cycles after accept; wbm_cyc_i dropped mid-transfer -> slave cyc low next cycle, no ack.
REQ-030 With WB_NARROW_SEQ_TIMEOUT_EN, TIMEOUT=4, silent slave -> wbm_err_o after 4 cycles; reset asserted mid-access -> all outputs 0 next cycle.

Source files
------------

// File: rtl/wb_narrow_seq.sv
`default_nettype none
// ============================================================================
// Module  : wb_narrow_seq
// Brief   : Splits a 32-bit classic Wishbone access into big-endian 8-bit
//           slave accesses, one per selected byte lane. Optional slave
//           watchdog enabled by defining WB_NARROW_SEQ_TIMEOUT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module wb_narrow_seq #(
    parameter int unsigned aw      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [7:0]    wbs_dat_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [7:0]    wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RETRY  = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    function automatic logic [1:0] top_lane(input logic [3:0] bits);
        if (bits[3]) return 2'd3;
        if (bits[2]) return 2'd2;
        if (bits[1]) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] k);
        return d[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sel_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    logic [1:0]    r_state, w_state;
    logic [aw-3:0] r_adr, w_adr;
    logic [31:0]   r_dat, w_dat;
    logic [3:0]    r_sel, w_sel;
    logic [3:0]    r_pend, w_pend;
    logic [31:0]   r_buf, w_buf;
    logic [1:0]    r_lane, w_lane;
    logic          r_err_flag, w_err_flag;
    logic          r_wbs_cyc, w_wbs_cyc;
    logic          r_wbs_stb, w_wbs_stb;
    logic          r_wbs_we, w_wbs_we;
    logic [aw-1:0] r_wbs_adr, w_wbs_adr;
    logic [7:0]    r_wbs_dat, w_wbs_dat;
    logic          r_ack, w_ack;
    logic          r_err, w_err;
    logic [31:0]   r_mdat, w_mdat;
    logic [3:0]    w_pend_left;
    logic [1:0]    w_next_lane;
    logic [1:0]    w_first_lane;

`ifdef WB_NARROW_SEQ_TIMEOUT_EN
    localparam logic [15:0] c_WDOG_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_wdog, w_wdog;
`else
    localparam int unsigned c_unused_timeout = TIMEOUT;
`endif

    logic w_unused;
    assign w_unused = &{1'b0, wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};

    assign w_pend_left  = r_pend & ~(4'b0001 << r_lane);
    assign w_next_lane  = top_lane(w_pend_left);
    assign w_first_lane = top_lane(wbm_sel_i);

    always_comb begin
        w_state    = r_state;
        w_adr      = r_adr;
        w_dat      = r_dat;
        w_sel      = r_sel;
        w_pend     = r_pend;
        w_buf      = r_buf;
        w_lane     = r_lane;
        w_err_flag = r_err_flag;
        w_wbs_cyc  = r_wbs_cyc;
        w_wbs_stb  = r_wbs_stb;
        w_wbs_we   = r_wbs_we;
        w_wbs_adr  = r_wbs_adr;
        w_wbs_dat  = r_wbs_dat;
        w_ack      = 1'b0;
        w_err      = 1'b0;
        w_mdat     = 32'd0;
`ifdef WB_NARROW_SEQ_TIMEOUT_EN
        w_wdog     = r_wdog;
`endif
        case (r_state)
            c_IDLE: begin
                // The master still holds stb during our ack/err cycle; do not re-accept it.
                if (wbm_cyc_i && wbm_stb_i && !r_ack && !r_err) begin
                    w_adr      = wbm_adr_i[aw-1:2];
                    w_dat      = wbm_dat_i;
                    w_sel      = wbm_sel_i;
                    w_pend     = wbm_sel_i;
                    w_buf      = 32'd0;
                    w_err_flag = 1'b0;
                    if (wbm_sel_i == 4'b0000) begin
                        w_state = c_RESP;
                    end else begin
                        w_state   = c_ACCESS;
                        w_lane    = w_first_lane;
                        w_wbs_cyc = 1'b1;
                        w_wbs_stb = 1'b1;
                        w_wbs_we  = wbm_we_i;
                        // Big-endian: lane k lives at byte offset 3-k, i.e. ~k.
                        w_wbs_adr = {wbm_adr_i[aw-1:2], ~w_first_lane};
                        w_wbs_dat = lane_byte(wbm_dat_i, w_first_lane);
`ifdef WB_NARROW_SEQ_TIMEOUT_EN
                        w_wdog    = 16'd0;
`endif
                    end
                end
            end
            c_ACCESS: begin
                if (!wbm_cyc_i) begin
                    w_wbs_cyc = 1'b0;
                    w_wbs_stb = 1'b0;
                    w_wbs_we  = 1'b0;
                    w_pend    = 4'b0000;
                    w_state   = c_IDLE;
                end else if (wbs_err_i) begin
                    w_wbs_cyc  = 1'b0;
                    w_wbs_stb  = 1'b0;
                    w_wbs_we   = 1'b0;
                    w_pend     = 4'b0000;
                    w_err_flag = 1'b1;
                    w_state    = c_RESP;
                end else if (wbs_ack_i) begin
                    w_buf[{r_lane, 3'b000} +: 8] = wbs_dat_i;
                    w_pend = w_pend_left;
`ifdef WB_NARROW_SEQ_TIMEOUT_EN
                    w_wdog = 16'd0;
`endif
                    if (w_pend_left == 4'b0000) begin
                        w_wbs_cyc = 1'b0;
                        w_wbs_stb = 1'b0;
                        w_wbs_we  = 1'b0;
                        w_state   = c_RESP;
                    end else begin
                        w_lane    = w_next_lane;
                        w_wbs_adr = {r_adr, ~w_next_lane};
                        w_wbs_dat = lane_byte(r_dat, w_next_lane);
                    end
                end else if (wbs_rty_i) begin
                    w_wbs_stb = 1'b0;
                    w_state   = c_RETRY;
                end
`ifdef WB_NARROW_SEQ_TIMEOUT_EN
                else if (r_wdog == c_WDOG_LAST) begin
                    w_wbs_cyc  = 1'b0;
                    w_wbs_stb  = 1'b0;
                    w_wbs_we   = 1'b0;
                    w_pend     = 4'b0000;
                    w_err_flag = 1'b1;
                    w_state    = c_RESP;
                end else begin
                    w_wdog = r_wdog + 16'd1;
                end
`endif
            end
            c_RETRY: begin
                if (!wbm_cyc_i) begin
                    w_wbs_cyc = 1'b0;
                    w_wbs_stb = 1'b0;
                    w_wbs_we  = 1'b0;
                    w_pend    = 4'b0000;
                    w_state   = c_IDLE;
                end else begin
                    w_wbs_stb = 1'b1;
                    w_state   = c_ACCESS;
`ifdef WB_NARROW_SEQ_TIMEOUT_EN
                    w_wdog    = 16'd0;
`endif
                end
            end
            default: begin
                w_state = c_IDLE;
                if (r_err_flag) begin
                    w_err = 1'b1;
                end else begin
                    w_ack  = 1'b1;
                    w_mdat = r_buf & sel_mask(r_sel);
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state    <= c_IDLE;
            r_adr      <= '0;
            r_dat      <= 32'd0;
            r_sel      <= 4'd0;
            r_pend     <= 4'd0;
            r_buf      <= 32'd0;
            r_lane     <= 2'd0;
            r_err_flag <= 1'b0;
            r_wbs_cyc  <= 1'b0;
            r_wbs_stb  <= 1'b0;
            r_wbs_we   <= 1'b0;
            r_wbs_adr  <= '0;
            r_wbs_dat  <= 8'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_mdat     <= 32'd0;
`ifdef WB_NARROW_SEQ_TIMEOUT_EN
            r_wdog     <= 16'd0;
`endif
        end else begin
            r_state    <= w_state;
            r_adr      <= w_adr;
            r_dat      <= w_dat;
            r_sel      <= w_sel;
            r_pend     <= w_pend;
            r_buf      <= w_buf;
            r_lane     <= w_lane;
            r_err_flag <= w_err_flag;
            r_wbs_cyc  <= w_wbs_cyc;
            r_wbs_stb  <= w_wbs_stb;
            r_wbs_we   <= w_wbs_we;
            r_wbs_adr  <= w_wbs_adr;
            r_wbs_dat  <= w_wbs_dat;
            r_ack      <= w_ack;
            r_err      <= w_err;
            r_mdat     <= w_mdat;
`ifdef WB_NARROW_SEQ_TIMEOUT_EN
            r_wdog     <= w_wdog;
`endif
        end
    end

    assign wbm_dat_o = r_mdat;
    assign wbm_ack_o = r_ack;
    assign wbm_err_o = r_err;
    assign wbm_rty_o = 1'b0;
    assign wbs_adr_o = r_wbs_adr;
    assign wbs_dat_o = r_wbs_dat;
    assign wbs_we_o  = r_wbs_we;
    assign wbs_cyc_o = r_wbs_cyc;
    assign wbs_stb_o = r_wbs_stb;
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_wb_narrow_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_narrow_seq
// Brief   : Directed self-checking bench for wb_narrow_seq with a scripted
//           8-bit slave. Timeout case compiled when WB_NARROW_SEQ_TIMEOUT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_wb_narrow_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbm_adr_i;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_i;
    logic        wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [2:0]  wbm_cti_i;
    logic [1:0]  wbm_bte_i;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs_adr_o;
    logic [7:0]  wbs_dat_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic [7:0]  wbs_dat_i;
    logic        wbs_ack_i, wbs_err_i, wbs_rty_i;

    always #5 clk = ~clk;

    wb_narrow_seq #(.aw(32), .TIMEOUT(4)) u_dut (
        .wb_clk_i (clk),       .wb_rst_i (rst_n),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i (wbm_we_i),  .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o (wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o),
        .wbs_bte_o(wbs_bte_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  mem [4];
    int          n_iss, gap_cnt, ack_cnt, m_err_cnt, resp_cyc;
    logic [31:0] iss_adr [8];
    logic [7:0]  iss_dat [8];
    logic        iss_we  [8];
    logic [31:0] got_dat;
    logic        side_bad;
    logic        seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One master transaction; cycle c counts edges from (and including) the accept edge.
    task automatic run_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, input int err_at, input int rty_at, input bit silent);
        int c;
        int post;
        n_iss = 0; gap_cnt = 0; ack_cnt = 0; m_err_cnt = 0; resp_cyc = -1;
        got_dat = 32'd0; side_bad = 1'b0;
        wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel; wbm_we_i = we;
        wbm_cti_i = 3'b010; wbm_bte_i = 2'b01;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        c = 0; post = 0;
        while (post <= 3 && c <= 40) begin
            @(posedge clk); #1; c++;
            wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0; wbs_dat_i = 8'd0;
            if (wbm_ack_o || wbm_err_o) begin
                if (wbm_ack_o) begin ack_cnt++; got_dat = wbm_dat_o; end
                if (wbm_err_o) m_err_cnt++;
                if (resp_cyc < 0) resp_cyc = c;
                wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
            end else if (wbm_dat_o != 32'd0) begin
                side_bad = 1'b1;
            end
            if (wbs_cti_o != 3'd0 || wbs_bte_o != 2'd0 || wbm_rty_o) side_bad = 1'b1;
            if (wbs_cyc_o && !wbs_stb_o) gap_cnt++;
            if (wbs_cyc_o && wbs_stb_o) begin
                if (n_iss < 8) begin
                    iss_adr[n_iss] = wbs_adr_o; iss_dat[n_iss] = wbs_dat_o; iss_we[n_iss] = wbs_we_o;
                end
                if (!silent) begin
                    if (n_iss == err_at) wbs_err_i = 1'b1;
                    else if (n_iss == rty_at) wbs_rty_i = 1'b1;
                    else begin
                        wbs_ack_i = 1'b1;
                        if (!wbs_we_o) wbs_dat_i = mem[wbs_adr_o[1:0]];
                    end
                end
                n_iss++;
            end
            if (resp_cyc >= 0) post++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wbm_adr_i = 32'd0; wbm_dat_i = 32'd0; wbm_sel_i = 4'd0; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_cti_i = 3'd0; wbm_bte_i = 2'd0;
        wbs_dat_i = 8'd0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ctrl", {27'd0, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_err_o}, 32'd0);
        check_val("rst_mdat", wbm_dat_o, 32'd0);
        check_val("rst_sadr", wbs_adr_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word read
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        run_xfer(32'h100, 32'h0, 4'b1111, 1'b0, -1, -1, 1'b0);
        check_val("rd_niss", n_iss, 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("rd_adr%0d", i), iss_adr[i], 32'h100 + i);
        check_val("rd_we", {28'd0, iss_we[0], iss_we[1], iss_we[2], iss_we[3]}, 32'd0);
        check_val("rd_dat", got_dat, 32'h11223344);
        check_val("rd_acks", ack_cnt, 1);
        check_val("rd_errs", m_err_cnt, 0);
        check_val("rd_lat", resp_cyc, 6);
        check_val("rd_side", {31'd0, side_bad}, 32'd0);

        // Two-lane write
        run_xfer(32'h204, 32'hAABBCCDD, 4'b0011, 1'b1, -1, -1, 1'b0);
        check_val("wr_niss", n_iss, 2);
        check_val("wr_adr0", iss_adr[0], 32'h206);
        check_val("wr_dat0", {24'd0, iss_dat[0]}, 32'hCC);
        check_val("wr_adr1", iss_adr[1], 32'h207);
        check_val("wr_dat1", {24'd0, iss_dat[1]}, 32'hDD);
        check_val("wr_we", {30'd0, iss_we[0], iss_we[1]}, 32'd3);
        check_val("wr_acks", ack_cnt, 1);
        check_val("wr_lat", resp_cyc, 4);

        // Sparse read, lanes 3 and 1
        mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
        run_xfer(32'h400, 32'h0, 4'b1010, 1'b0, -1, -1, 1'b0);
        check_val("sp_niss", n_iss, 2);
        check_val("sp_adr0", iss_adr[0], 32'h400);
        check_val("sp_adr1", iss_adr[1], 32'h402);
        check_val("sp_dat", got_dat, 32'hA000A200);
        check_val("sp_side", {31'd0, side_bad}, 32'd0);

        // Slave error on second byte
        run_xfer(32'h100, 32'h0, 4'b1111, 1'b0, 1, -1, 1'b0);
        check_val("er_niss", n_iss, 2);
        check_val("er_errs", m_err_cnt, 1);
        check_val("er_acks", ack_cnt, 0);
        check_val("er_lat", resp_cyc, 4);
        check_val("er_side", {31'd0, side_bad}, 32'd0);

        // Retry once then ack
        mem[1] = 8'h5A;
        run_xfer(32'h300, 32'h0, 4'b0100, 1'b0, -1, 0, 1'b0);
        check_val("ry_niss", n_iss, 2);
        check_val("ry_gap", gap_cnt, 1);
        check_val("ry_adr0", iss_adr[0], 32'h301);
        check_val("ry_adr1", iss_adr[1], 32'h301);
        check_val("ry_dat", got_dat, 32'h005A0000);
        check_val("ry_lat", resp_cyc, 5);

        // No lanes selected
        run_xfer(32'h800, 32'h0, 4'b0000, 1'b0, -1, -1, 1'b0);
        check_val("z_niss", n_iss, 0);
        check_val("z_gap", gap_cnt, 0);
        check_val("z_acks", ack_cnt, 1);
        check_val("z_lat", resp_cyc, 2);
        check_val("z_dat", got_dat, 32'd0);

        // Master abandons the cycle mid-transfer
        wbm_adr_i = 32'h500; wbm_sel_i = 4'b1111; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        @(posedge clk); #1;
        check_val("ab_pre", {31'd0, wbs_cyc_o}, 32'd1);
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        @(posedge clk); #1;
        check_val("ab_cyc", {30'd0, wbs_cyc_o, wbs_stb_o}, 32'd0);
        seen = 1'b0;
        repeat (4) begin
            if (wbm_ack_o || wbm_err_o || wbs_cyc_o) seen = 1'b1;
            @(posedge clk); #1;
        end
        check_val("ab_noresp", {31'd0, seen}, 32'd0);

        // Reset asserted mid-access
        wbm_adr_i = 32'h600; wbm_dat_i = 32'hFFFFFFFF; wbm_sel_i = 4'b1111; wbm_we_i = 1'b1;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rm_pre", {31'd0, wbs_cyc_o}, 32'd1);
        rst_n = 1'b0; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        @(posedge clk); #1;
        check_val("rm_ctrl", {27'd0, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_err_o}, 32'd0);
        check_val("rm_sdat", {24'd0, wbs_dat_o}, 32'd0);
        check_val("rm_sadr", wbs_adr_o, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wbm_ack_o || wbm_err_o) seen = 1'b1;
        end
        check_val("rm_noresp", {31'd0, seen}, 32'd0);

`ifdef WB_NARROW_SEQ_TIMEOUT_EN
        // Silent slave trips the watchdog after four access cycles
        run_xfer(32'h700, 32'h0, 4'b0001, 1'b0, -1, -1, 1'b1);
        check_val("to_niss", n_iss, 4);
        check_val("to_errs", m_err_cnt, 1);
        check_val("to_acks", ack_cnt, 0);
        check_val("to_lat", resp_cyc, 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
